// File: rtl/spi_cfg_pkg.sv
// Shared constants and types for the SPI configuration front end.
package spi_cfg_pkg;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;

    localparam logic [7:0] CMD_CONF_WR = 8'h2A;
    localparam logic [7:0] CMD_INFO_RD = 8'h3A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONF_WR,
        ST_INFO_RD
    } state_t;
endpackage

// File: rtl/spi_byte_if.sv
// SPI mode 0 slave byte engine: input synchronizers, SCLK edge detect,
// RX/TX shift registers and the bit counter shared by both directions.
module spi_byte_if
    import spi_cfg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       mosi,
    input  logic       cs_n,
    input  logic       dc,
    input  logic [7:0] tx_data,
    output logic       byte_vld,
    output logic [7:0] byte_data,
    output logic       byte_dc,
    output logic       cs_active,
    output logic       miso
);
    logic [1:0] sclk_sync, mosi_sync, cs_sync, dc_sync;
    logic       sclk_q, cs_q;
    logic [2:0] bit_cnt;
    logic [7:0] rx_sh, tx_sh;
    logic       sclk_s, mosi_s, cs_s, dc_s;
    logic       rise, fall, cs_fall;

    assign sclk_s  = sclk_sync[1];
    assign mosi_s  = mosi_sync[1];
    assign cs_s    = cs_sync[1];
    assign dc_s    = dc_sync[1];
    assign rise    = sclk_s & ~sclk_q;
    assign fall    = ~sclk_s & sclk_q;
    assign cs_fall = ~cs_s & cs_q;

    assign cs_active = ~cs_s;
    assign miso      = tx_sh[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync <= 2'b00;
            mosi_sync <= 2'b00;
            cs_sync   <= 2'b11;   // chip deselected out of reset
            dc_sync   <= 2'b00;
            sclk_q    <= 1'b0;
            cs_q      <= 1'b1;
            bit_cnt   <= 3'd0;
            rx_sh     <= 8'h00;
            tx_sh     <= 8'h00;
            byte_vld  <= 1'b0;
            byte_data <= 8'h00;
            byte_dc   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            mosi_sync <= {mosi_sync[0], mosi};
            cs_sync   <= {cs_sync[0], cs_n};
            dc_sync   <= {dc_sync[0], dc};
            sclk_q    <= sclk_s;
            cs_q      <= cs_s;
            byte_vld  <= 1'b0;
            if (cs_s) begin
                bit_cnt <= 3'd0;
                tx_sh   <= 8'h00;
            end else begin
                if (rise) begin
                    rx_sh   <= {rx_sh[6:0], mosi_s};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_vld  <= 1'b1;
                        byte_data <= {rx_sh[6:0], mosi_s};
                        byte_dc   <= dc_s;
                    end
                end
                // A fall at a byte boundary presents the next byte's MSB.
                if (cs_fall || (fall && bit_cnt == 3'd0))
                    tx_sh <= tx_data;
                else if (fall)
                    tx_sh <= {tx_sh[6:0], 1'b0};
            end
        end
    end
endmodule

// File: rtl/spi_cfg_frontend.sv
// SPI configuration front end: command FSM and 8x8 register file on top of
// the byte engine; registers are exported as a flat bus.
module spi_cfg_frontend
    import spi_cfg_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dc_i,
    input  logic        spi_sclk_i,
    input  logic        spi_mosi_i,
    input  logic        spi_cs_n_i,
    output logic        spi_miso_o,
    output logic [63:0] reg_data_o
);
    logic              byte_vld, byte_dc, cs_active, wr_en;
    logic [7:0]        byte_data, rd_data;
    logic [ADDR_W-1:0] addr, addr_nx;
    state_t            state, state_nx;
    logic [7:0]        regs [NUM_REGS];

    assign rd_data = regs[addr];

    spi_byte_if u_byte_if (
        .clk       (clk_i),
        .rst       (rst_i),
        .sclk      (spi_sclk_i),
        .mosi      (spi_mosi_i),
        .cs_n      (spi_cs_n_i),
        .dc        (dc_i),
        .tx_data   (rd_data),
        .byte_vld  (byte_vld),
        .byte_data (byte_data),
        .byte_dc   (byte_dc),
        .cs_active (cs_active),
        .miso      (spi_miso_o)
    );

    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        wr_en    = 1'b0;
        // Deselect wins over a byte completing in the same cycle.
        if (!cs_active) begin
            state_nx = ST_IDLE;
            addr_nx  = '0;
        end else if (byte_vld) begin
            if (!byte_dc) begin
                case (byte_data)
                    CMD_CONF_WR: begin state_nx = ST_CONF_WR; addr_nx = '0; end
                    CMD_INFO_RD: begin state_nx = ST_INFO_RD; addr_nx = '0; end
                    default:     state_nx = ST_IDLE;
                endcase
            end else begin
                case (state)
                    ST_CONF_WR: begin wr_en = 1'b1; addr_nx = addr + 1'b1; end
                    ST_INFO_RD: addr_nx = addr + 1'b1;
                    default:    ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            addr       <= '0;
            reg_data_o <= 64'h0;
            for (int k = 0; k < NUM_REGS; k++) regs[k] <= 8'h00;
        end else begin
            state <= state_nx;
            addr  <= addr_nx;
            if (wr_en) regs[addr] <= byte_data;
            for (int k = 0; k < NUM_REGS; k++) reg_data_o[8*k +: 8] <= regs[k];
        end
    end
endmodule

// File: tb/tb_spi_cfg_frontend.sv
// Bench for spi_cfg_frontend: drives SPI mode 0 traffic and checks register
// contents and MISO read-back through an expected-value queue.
module tb_spi_cfg_frontend;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        dc_i = 1'b0;
    logic        spi_sclk_i = 1'b0;
    logic        spi_mosi_i = 1'b0;
    logic        spi_cs_n_i = 1'b1;
    logic        spi_miso_o;
    logic [63:0] reg_data_o;

    int n_chk = 0;
    int n_err = 0;
    logic [63:0] exp_q [$];
    logic [7:0]  rx;

    spi_cfg_frontend dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .dc_i       (dc_i),
        .spi_sclk_i (spi_sclk_i),
        .spi_mosi_i (spi_mosi_i),
        .spi_cs_n_i (spi_cs_n_i),
        .spi_miso_o (spi_miso_o),
        .reg_data_o (reg_data_o)
    );

    always #2.5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    // SCLK half period = 3 clk_i cycles; MISO sampled at the rising edge.
    task automatic spi_bits(input logic dc, input logic [7:0] tx, input int nbits,
                            output logic [7:0] rxb);
        rxb = 8'h00;
        dc_i = dc;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi_i = tx[7-i];
            clks(3);
            spi_sclk_i = 1'b1;
            rxb = {rxb[6:0], spi_miso_o};
            clks(3);
            spi_sclk_i = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic dc, input logic [7:0] tx);
        logic [7:0] dummy;
        spi_bits(dc, tx, 8, dummy);
    endtask

    task automatic cs_low();
        spi_cs_n_i = 1'b0;
        clks(4);
    endtask

    task automatic cs_high();
        clks(3);
        spi_cs_n_i = 1'b1;
        clks(6);
    endtask

    task automatic pulse_rst();
        rst_i = 1'b1;
        clks(2);
        rst_i = 1'b0;
        clks(4);
    endtask

    task automatic expect_regs(input string tag, input logic [63:0] v);
        exp_q.push_back(v);
        clks(8);
        chk(tag, reg_data_o, exp_q.pop_front());
    endtask

    initial begin
        clks(3);
        rst_i = 1'b0;
        clks(2);
        chk("reset_regs", reg_data_o, 64'h0);
        chk("reset_miso", {63'h0, spi_miso_o}, 64'h0);

        // Fill with 0xFF, wrapping past reg 7
        cs_low();
        spi_byte(1'b0, 8'h2A);
        for (int i = 0; i < 10; i++) spi_byte(1'b1, 8'hFF);
        expect_regs("fill_ff", 64'hFFFF_FFFF_FFFF_FFFF);
        cs_high();

        // Write 01..08, then read back ten bytes
        cs_low();
        spi_byte(1'b0, 8'h2A);
        for (int i = 1; i <= 8; i++) spi_byte(1'b1, 8'(i));
        spi_byte(1'b0, 8'h3A);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(64'((i % 8) + 1));
            spi_bits(1'b1, 8'h00, 8, rx);
            chk($sformatf("miso_rd%0d", i), {56'h0, rx}, exp_q.pop_front());
        end
        cs_high();
        chk("miso_cs_high", {63'h0, spi_miso_o}, 64'h0);
        expect_regs("after_rd", 64'h0807_0605_0403_0201);

        // Unknown command, then data: ignored
        cs_low();
        spi_byte(1'b0, 8'h55);
        spi_byte(1'b1, 8'hAA);
        expect_regs("unknown_cmd", 64'h0807_0605_0403_0201);
        cs_high();

        // Partial byte dropped by CS deassert
        pulse_rst();
        cs_low();
        spi_bits(1'b0, 8'h2A, 8, rx);
        spi_bits(1'b1, 8'hC3, 4, rx);
        cs_high();
        cs_low();
        spi_byte(1'b0, 8'h2A);
        spi_byte(1'b1, 8'h5A);
        expect_regs("partial_drop", 64'h0000_0000_0000_005A);
        cs_high();

        // Reset in the middle of a data byte
        cs_low();
        spi_byte(1'b0, 8'h2A);
        spi_byte(1'b1, 8'h33);
        spi_byte(1'b1, 8'h44);
        expect_regs("pre_rst", 64'h0000_0000_0000_4433);
        spi_bits(1'b1, 8'h99, 4, rx);
        clks(4);
        pulse_rst();
        chk("mid_rst", reg_data_o, 64'h0);
        spi_byte(1'b0, 8'h2A);
        spi_byte(1'b1, 8'h11);
        expect_regs("post_rst", 64'h0000_0000_0000_0011);
        cs_high();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
